// File: rtl/addsub_pipelined_segmented_pkg.sv
// rtl/addsub_pipelined_segmented_pkg.sv - ALU add/sub opcode constants and segment-count helper
package addsub_pipelined_segmented_pkg;

  // Encoding of the sub_add control bit
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Number of slices needed to cover a word; the top slice may be narrower
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/addsub_segment_stage.sv
// rtl/addsub_segment_stage.sv - one pipeline stage: slice adder plus operand-skew/result-deskew registers
module addsub_segment_stage
  import addsub_pipelined_segmented_pkg::*;
#(
  parameter int WORD_WIDTH = 36,
  parameter int LO         = 0,
  parameter int W          = 12
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  advance,
  input  logic                  valid_in,
  input  logic                  sub_in,
  input  logic                  carry_in,
  input  logic [WORD_WIDTH-1:0] a_in,
  input  logic [WORD_WIDTH-1:0] b_in,
  input  logic [WORD_WIDTH-1:0] sum_in,
  output logic                  valid_out,
  output logic                  sub_out,
  output logic                  carry_out,
  output logic [WORD_WIDTH-1:0] a_out,
  output logic [WORD_WIDTH-1:0] b_out,
  output logic [WORD_WIDTH-1:0] sum_out,
  output logic [WORD_WIDTH-1:0] sum_next,
  output logic                  carry_next
);

  logic [W:0] slice_sum;

  // Add this stage's slice and splice it into the partially assembled word
  always_comb begin
    slice_sum = {1'b0, a_in[LO +: W]} + {1'b0, b_in[LO +: W]} + {{W{1'b0}}, carry_in};
    sum_next = sum_in;
    sum_next[LO +: W] = slice_sum[W-1:0];
    carry_next = slice_sum[W];
  end

  // Stage register; everything holds while the pipeline is stalled
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_out <= 1'b0;
      sub_out   <= 1'b0;
      carry_out <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
      sum_out   <= '0;
    end else if (advance) begin
      valid_out <= valid_in;
      sub_out   <= sub_in;
      carry_out <= carry_next;
      a_out     <= a_in;
      b_out     <= b_in;
      sum_out   <= sum_next;
    end
  end

endmodule

// File: rtl/addsub_pipelined_segmented.sv
// rtl/addsub_pipelined_segmented.sv - pipelined segmented add/subtract unit with valid/ready and flags
module addsub_pipelined_segmented
  import addsub_pipelined_segmented_pkg::*;
#(
  parameter int WORD_WIDTH    = 36,
  parameter int SEGMENT_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  sub_add,
  input  logic                  carry_in,
  input  logic [WORD_WIDTH-1:0] A,
  input  logic [WORD_WIDTH-1:0] B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] sum,
  output logic                  carry_out,
  output logic                  overflow,
  output logic                  zero
);

  localparam int NUM_SEGMENTS = ceil_div(WORD_WIDTH, SEGMENT_WIDTH);
  localparam int LAST         = NUM_SEGMENTS - 1;
  localparam int MSB          = WORD_WIDTH - 1;

  // Index k is the input of stage k; index NUM_SEGMENTS is the output register
  logic [NUM_SEGMENTS:0]                 valid_ch;
  logic [NUM_SEGMENTS:0]                 sub_ch;
  logic [NUM_SEGMENTS:0]                 carry_ch;
  logic [NUM_SEGMENTS:0][WORD_WIDTH-1:0] a_ch;
  logic [NUM_SEGMENTS:0][WORD_WIDTH-1:0] b_ch;
  logic [NUM_SEGMENTS:0][WORD_WIDTH-1:0] sum_ch;
  logic [LAST:0][WORD_WIDTH-1:0]         sum_nx;
  logic [LAST:0]                         carry_nx;
  logic [WORD_WIDTH-1:0]                 final_sum;
  logic                                  advance;
  logic                                  unused_tail;

  // Single global stall: every stage holds while a result waits unaccepted
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Subtract runs as A + ~B + ~carry_in so the slice adders never change mode
  assign valid_ch[0] = in_valid;
  assign sub_ch[0]   = sub_add;
  assign a_ch[0]     = A;
  assign b_ch[0]     = (sub_add == OP_SUB) ? ~B : B;
  assign carry_ch[0] = (sub_add == OP_SUB) ? ~carry_in : carry_in;
  assign sum_ch[0]   = '0;

  for (genvar k = 0; k < NUM_SEGMENTS; k++) begin : g_stage
    localparam int LO = k * SEGMENT_WIDTH;
    localparam int SW = (k == LAST) ? (WORD_WIDTH - LO) : SEGMENT_WIDTH;

    addsub_segment_stage #(
      .WORD_WIDTH (WORD_WIDTH),
      .LO         (LO),
      .W          (SW)
    ) u_stage (
      .clock      (clock),
      .reset_n    (reset_n),
      .advance    (advance),
      .valid_in   (valid_ch[k]),
      .sub_in     (sub_ch[k]),
      .carry_in   (carry_ch[k]),
      .a_in       (a_ch[k]),
      .b_in       (b_ch[k]),
      .sum_in     (sum_ch[k]),
      .valid_out  (valid_ch[k+1]),
      .sub_out    (sub_ch[k+1]),
      .carry_out  (carry_ch[k+1]),
      .a_out      (a_ch[k+1]),
      .b_out      (b_ch[k+1]),
      .sum_out    (sum_ch[k+1]),
      .sum_next   (sum_nx[k]),
      .carry_next (carry_nx[k])
    );
  end

  assign final_sum = sum_nx[LAST];
  assign out_valid = valid_ch[NUM_SEGMENTS];
  assign sum       = sum_ch[NUM_SEGMENTS];

  // Flags come from the fully assembled word and are registered alongside it.
  // With B already conditioned, one overflow form covers both add and subtract.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (advance) begin
      carry_out <= carry_nx[LAST] ^ sub_ch[LAST];
      overflow  <= (a_ch[LAST][MSB] == b_ch[LAST][MSB]) && (final_sum[MSB] != a_ch[LAST][MSB]);
      zero      <= (final_sum == '0);
    end
  end

  // Operand copies and raw carry leaving the last stage have no consumer
  assign unused_tail = ^{a_ch[NUM_SEGMENTS], b_ch[NUM_SEGMENTS], sub_ch[NUM_SEGMENTS],
                         carry_ch[NUM_SEGMENTS], sum_nx, carry_nx};

endmodule

// File: doc/addsub_pipelined_segmented.md
Name: addsub_pipelined_segmented

Overview:
- Parametrised, pipelined add/subtract unit: next generation of the single-cycle ALU adder/subtractor.
- Splits the word into SEGMENT_WIDTH slices and ripples the carry/borrow through one register stage per slice. Wide words therefore close timing at high clock rates.
- Adds a valid/ready handshake with backpressure and produces carry/borrow, signed-overflow and zero flags.
- Sits between the operand-read and write-back stages of the ALU.

Parameters:
- WORD_WIDTH, 36, operand/result width in bits (>=2).
- SEGMENT_WIDTH, 12, bits computed per pipeline stage (1..WORD_WIDTH).
- NUM_SEGMENTS, derived = ceil(WORD_WIDTH/SEGMENT_WIDTH). Not overridable. The last segment may be narrower.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands presented.
- in_ready  out  1  unit accepts operands this cycle.
- sub_add  in  1  1 = A-B-carry_in, 0 = A+B+carry_in.
- carry_in  in  1  carry (add) or borrow (sub) into bit 0.
- A  in  WORD_WIDTH  signed operand.
- B  in  WORD_WIDTH  signed operand.
- out_valid  out  1  result presented.
- out_ready  in  1  consumer accepts result.
- sum  out  WORD_WIDTH  result.
- carry_out  out  1  add: carry out of MSB; sub: borrow (1 when A-B-carry_in < 0 as unsigned).
- overflow  out  1  signed two's-complement overflow.
- zero  out  1  sum == 0.

Behaviour:
- Reset (reset_n low, async): all stage valid bits = 0, out_valid = 0, sum = 0, carry_out = 0, overflow = 0, zero = 0. Data registers clear to 0.
- Release of reset is sampled synchronously; the first transfer is possible on the first rising edge with reset_n high.
- Arithmetic is identical to the single-cycle unit, bit-exact over WORD_WIDTH+1 bits:
  - add: {carry_out,sum} = A+B+carry_in.
  - sub: {carry_out,sum} = A-B-carry_in.
- Subtract is implemented as A + ~B + ~carry_in; the internal final carry is inverted to give the borrow.
- overflow: add = (A[msb]==B[msb]) && (sum[msb]!=A[msb]); sub = (A[msb]!=B[msb]) && (sum[msb]!=A[msb]).
- Stage k (0..NUM_SEGMENTS-1):
  - Adds slice k of the operands plus the registered carry from stage k-1 (stage 0 uses the conditioned carry_in).
  - Registers the partial sum slice and the carry.
  - Passes higher, not-yet-used operand slices forward (skew registers). Lower result slices are carried along (deskew).
- Latency: exactly NUM_SEGMENTS cycles from accepted input to out_valid, with no stalls. Throughput is 1 op/cycle.
- Handshake:
  - Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
  - in_ready = !out_valid || out_ready. This is a global stall: all stages hold when out_valid && !out_ready.
  - During a stall sum/flags/out_valid stay stable. in_ready is combinationally dependent on out_ready only.
  - Bubbles (in_valid=0) propagate as invalid stages. Data in invalid stages is don't-care, but the flags are still registered.
- Simultaneous in and out transfer in one cycle: both occur; the pipeline advances.
- sub_add and carry_in are sampled with the operands and travel with them. Mixed add/sub streams are legal back-to-back.
- NUM_SEGMENTS==1 degenerates to a one-register-stage unit with latency 1.
- Reset mid-operation: all in-flight results are discarded and no out_valid pulse follows.
- zero and overflow are computed in the final stage from the assembled sum. They are registered with it, so there is no extra latency.

Decomposition:
- Shared include (ALU constants header): SUB/ADD encoding of sub_add and the NUM_SEGMENTS ceiling-division function.
- One natural sub-module: addsub_segment_stage. It holds one slice adder with carry-in/out registers, the operand-skew and result-deskew registers, and a valid bit.
  - It is instantiated NUM_SEGMENTS times in a generate loop; the last instance is sized to the remainder width.
- The top level holds the handshake, the carry_in/B conditioning for subtract, and the flag logic.

Test Plan (WORD_WIDTH=36, SEGMENT_WIDTH=12, latency 3):
- Reset then add:
  - Stimulus: A=0x0_0000_0FFF, B=1, sub_add=0, carry_in=0, one beat.
  - Required: out_valid exactly 3 cycles later with sum=0x0_0000_1000, carry_out=0, zero=0.
- Cross-segment carry:
  - Stimulus: A=0xF_FFFF_FFFF, B=0, carry_in=1, add.
  - Required: sum=0, carry_out=1, zero=1, overflow=0.
- Subtract with borrow and overflow:
  - Stimulus 1: A=0, B=1, carry_in=0, sub. Required: sum=0xF_FFFF_FFFF, carry_out=1.
  - Stimulus 2: A=0x8_0000_0000, B=1, sub. Required: sum=0x7_FFFF_FFFF, overflow=1.
- Backpressure:
  - Stimulus: stream 5 back-to-back ops with out_ready held 0 for cycles 4-7.
  - Required: in_ready low during the stall; outputs stable; all 5 results in order, none lost or duplicated.
- Reset mid-flight:
  - Stimulus: issue 2 ops, assert reset_n low asynchronously for half a cycle after cycle 1.
  - Required: out_valid=0 immediately and no later results.
- Randomised check:
  - Stimulus: random A/B/sub_add/carry_in/in_valid/out_ready for 10k cycles.
  - Required: every result matches a 37-bit reference computation and the overflow/zero formulas.
